// File: rtl/alu_shift_pkg.sv
// Shared types and encodings for the iterative ALU shift unit.
package alu_shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    SHIFT_SLL = OP_SLL,
    SHIFT_SRL = OP_SRL,
    SHIFT_SRA = OP_SRA,
    SHIFT_ROR = OP_ROR
  } shift_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/alu_shift_stage.sv
// Combinational one-step shifter: moves data_i by k_i (0..STEP) bits per op_i.
// Rotate support is compiled in only when ALU_SHIFT_ROT_EN is defined.
module alu_shift_stage
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic [WIDTH-1:0]       data_i,
  input  logic [$clog2(STEP):0]  k_i,
  input  shift_op_t              op_i,
  input  logic                   fill_i,
  output logic [WIDTH-1:0]       data_o
);

  // Single-step shift; SRA fills from the captured sign, not the current MSB
  always_comb begin
    data_o = data_i;
    case (op_i)
      SHIFT_SLL: data_o = data_i << k_i;
      SHIFT_SRL: data_o = data_i >> k_i;
      SHIFT_SRA: data_o = WIDTH'({{WIDTH{fill_i}}, data_i} >> k_i);
`ifdef ALU_SHIFT_ROT_EN
      SHIFT_ROR: data_o = WIDTH'({data_i, data_i} >> k_i);
`endif
      default:   data_o = WIDTH'({{WIDTH{fill_i}}, data_i} >> k_i);
    endcase
  end

endmodule

// File: rtl/alu_shift_iter.sv
// Iterative shift engine: SLL/SRL/SRA by 0..WIDTH-1, at most STEP bits per cycle.
// Define ALU_SHIFT_ROT_EN to make op 2'b11 a rotate-right; otherwise it behaves as SRA.
module alu_shift_iter
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_start,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [AMT_W-1:0] ctrl_shiftamt,
  input  logic [1:0]       ctrl_shiftop,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_busy
);

  localparam int KW = $clog2(STEP) + 1;

  shift_state_t     state_q, state_d;
  logic [WIDTH-1:0] work_q;
  logic [AMT_W-1:0] remain_q;
  shift_op_t        op_q;
  logic             fill_q;
  logic [WIDTH-1:0] result_q;

  logic             accept_s;
  logic             last_step_s;
  logic [KW-1:0]    k_s;
  shift_op_t        op_cap_s;
  logic [WIDTH-1:0] stage_out_s;

  // Op decode at capture; without rotate support op 11 folds onto SRA
  always_comb begin
`ifdef ALU_SHIFT_ROT_EN
    op_cap_s = shift_op_t'(ctrl_shiftop);
`else
    if (ctrl_shiftop == OP_ROR) begin
      op_cap_s = SHIFT_SRA;
    end else begin
      op_cap_s = shift_op_t'(ctrl_shiftop);
    end
`endif
  end

  // Step size for this cycle: min(remaining, STEP)
  always_comb begin
    if (remain_q > AMT_W'(STEP)) begin
      k_s         = KW'(STEP);
      last_step_s = 1'b0;
    end else begin
      k_s         = KW'(remain_q);
      last_step_s = 1'b1;
    end
  end

  alu_shift_stage #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_stage (
    .data_i (work_q),
    .k_i    (k_s),
    .op_i   (op_q),
    .fill_i (fill_q),
    .data_o (stage_out_s)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE accepts a new start just like IDLE
  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (ctrl_start) begin
          accept_s = 1'b1;
          if (ctrl_shiftamt == {AMT_W{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (last_step_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Work datapath; result register loads only on entry to DONE
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      work_q   <= {WIDTH{1'b0}};
      remain_q <= {AMT_W{1'b0}};
      op_q     <= SHIFT_SLL;
      fill_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      work_q   <= data_operandA;
      remain_q <= ctrl_shiftamt;
      op_q     <= op_cap_s;
      fill_q   <= data_operandA[WIDTH-1];
      if (ctrl_shiftamt == {AMT_W{1'b0}}) begin
        result_q <= data_operandA;
      end else begin
        result_q <= result_q;
      end
    end else if (state_q == S_SHIFT) begin
      work_q   <= stage_out_s;
      remain_q <= remain_q - AMT_W'(k_s);
      if (last_step_s) begin
        result_q <= stage_out_s;
      end else begin
        result_q <= result_q;
      end
    end else begin
      work_q   <= work_q;
      remain_q <= remain_q;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    data_busy      = (state_q == S_SHIFT);
    data_resultRDY = (state_q == S_DONE);
    data_result    = result_q;
  end

endmodule
